// File: rtl/snoop_responder_if.sv
// Snoop bus message seen by every cache: valid, source core, line address, bus_tx.
// bus_tx encoding: 0 BUS_RD, 1 BUS_RDX, 2 BUS_UPGR, 3 BUS_FLUSH.
interface snoop_responder_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SRC_W = 2
);
    logic             valid;
    logic [SRC_W-1:0] source;
    logic [XLEN-1:0]  addr;
    logic [1:0]       bus_tx;

    modport master (output valid, source, addr, bus_tx);
    modport slave  (input  valid, source, addr, bus_tx);
endinterface

// File: rtl/snoop_responder.sv
// Per-core MESI snoop responder: filters own traffic, looks up the line state,
// applies the snoop transition, answers shared/dirty and sequences a dirty flush.
// MESI encoding on tag_state/state_wr_val: 0 I, 1 S, 2 E, 3 M.
// Optional statistics outputs hit_cnt/flush_cnt are built when SNOOP_STATS_EN is defined.
module snoop_responder #(
    parameter int unsigned CPU_ID      = 0,
    parameter int unsigned SHARED_HOLD = 1,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SRC_W       = 2
) (
    input  logic                clk,
    input  logic                rst,
    snoop_responder_if.slave    bus_msg,
    output logic                snoop_busy,
    output logic                tag_req,
    output logic [XLEN-1:0]     tag_addr,
    input  logic [1:0]          tag_state,
    output logic                state_wr,
    output logic [1:0]          state_wr_val,
    output logic                flush_req,
    input  logic                flush_ack,
    output logic                snoop_shared,
    output logic                snoop_dirty,
    output logic                protocol_err
`ifdef SNOOP_STATS_EN
    ,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         flush_cnt
`endif
);
    typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_t;
    typedef enum logic [1:0] {BUS_RD = 2'd0, BUS_RDX = 2'd1, BUS_UPGR = 2'd2, BUS_FLUSH = 2'd3} bus_tx_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, RESOLVE, FLUSH} state_t;

    localparam int unsigned HW = (SHARED_HOLD < 2) ? 1 : $clog2(SHARED_HOLD);

    state_t          state, state_nx;
    logic [XLEN-1:0] addr_q;
    bus_tx_t         tx_q;
    mesi_t           old_q;
    mesi_t           new_st;
    logic            upgr_err;
    logic            snoop_in;
    logic            accept;
    logic [HW-1:0]   hold_cnt;
    logic            hold_sh;
    logic            hold_dt;
    logic            hit;

    // A snoopable message from another core; rst gates accept so outputs stay 0 in reset.
    always_comb begin
        snoop_in = bus_msg.valid && (bus_msg.source != SRC_W'(CPU_ID)) &&
                   (bus_tx_t'(bus_msg.bus_tx) != BUS_FLUSH);
        accept   = (state == IDLE) && snoop_in && !rst;
        tag_addr = accept ? bus_msg.addr : addr_q;
        hit      = (old_q != MESI_I);
    end

    // MESI snoop transition for the captured transaction and looked-up state.
    always_comb begin
        new_st   = old_q;
        upgr_err = 1'b0;
        case (tx_q)
            BUS_RD:   new_st = (old_q == MESI_I) ? MESI_I : MESI_S;
            BUS_RDX:  new_st = MESI_I;
            BUS_UPGR: begin
                new_st   = MESI_I;
                upgr_err = (old_q == MESI_M) || (old_q == MESI_E);
            end
            default:  new_st = old_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx     = state;
        snoop_busy   = 1'b1;
        tag_req      = 1'b0;
        state_wr     = 1'b0;
        state_wr_val = MESI_I;
        flush_req    = 1'b0;
        protocol_err = 1'b0;
        case (state)
            IDLE: begin
                snoop_busy = accept;
                tag_req    = accept;
                if (accept) state_nx = LOOKUP;
            end
            LOOKUP: begin
                protocol_err = snoop_in;
                state_nx     = RESOLVE;
            end
            RESOLVE: begin
                state_wr     = !upgr_err && (new_st != old_q);
                state_wr_val = state_wr ? new_st : MESI_I;
                protocol_err = snoop_in || upgr_err;
                state_nx     = (!upgr_err && old_q == MESI_M) ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush_req    = 1'b1;
                protocol_err = snoop_in;
                if (flush_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture the accepted message and the looked-up line state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            tx_q   <= BUS_RD;
            old_q  <= MESI_I;
        end else begin
            if (accept) begin
                addr_q <= bus_msg.addr;
                tx_q   <= bus_tx_t'(bus_msg.bus_tx);
            end
            if (state == LOOKUP) old_q <= mesi_t'(tag_state);
        end
    end

    // The RESOLVE cycle drives shared/dirty directly; the counter extends them SHARED_HOLD-1 more cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            hold_sh  <= 1'b0;
            hold_dt  <= 1'b0;
        end else if (state == RESOLVE) begin
            hold_cnt <= HW'(SHARED_HOLD - 1);
            hold_sh  <= hit;
            hold_dt  <= (old_q == MESI_M);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Shared/dirty response.
    always_comb begin
        if (state == RESOLVE) begin
            snoop_shared = hit;
            snoop_dirty  = (old_q == MESI_M);
        end else begin
            snoop_shared = (hold_cnt != '0) && hold_sh;
            snoop_dirty  = (hold_cnt != '0) && hold_dt;
        end
    end

`ifdef SNOOP_STATS_EN
    // Saturating hit and flush counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == RESOLVE && hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (state == FLUSH && flush_ack && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule
